univ_shift_reg: RTL and testbench

Parametrised successor to the team's plain 8-bit parallel-in/parallel-out register. It keeps the enable-gated parallel load and adds selectable shift and rotate modes, serial in/out, and an autonomous serial-transfer sequencer. It is the staging register for the Comparator datapath and can hold an operand or serialise it out one bit per clock.

---
 rtl/univ_shift_reg.sv | 106 ++++++++++
 tb/tb_univ_shift_reg.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, shift/rotate modes and an
// autonomous LSB-first serial transfer sequencer (IDLE/XFER).
module univ_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             SerInL,
  input  logic             SerInR,
  input  logic             Start,
  output logic [WIDTH-1:0] DataOut,
  output logic             SerOut,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_next;
  logic             r_done;
  logic             w_done_next;
  logic             w_last_shift;

  assign w_last_shift = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (En && Start)        w_state_next = ST_XFER;
      ST_XFER: if (En && w_last_shift) w_state_next = ST_IDLE;
      default:                         w_state_next = ST_IDLE;
    endcase
  end

  // Datapath and counter; Start only matters in IDLE, Mode only in IDLE without Start.
  always_comb begin
    w_data_next = r_data;
    w_cnt_next  = r_cnt;
    w_done_next = 1'b0;
    if (En) begin
      if (r_state == ST_IDLE) begin
        if (Start) begin
          w_data_next = DataIn;
          w_cnt_next  = '0;
        end else begin
          case (Mode)
            3'b000: w_data_next = r_data;
            3'b001: w_data_next = DataIn;
            3'b010: w_data_next = {r_data[WIDTH-2:0], SerInR};
            3'b011: w_data_next = {SerInL, r_data[WIDTH-1:1]};
            3'b100: w_data_next = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
            3'b101: w_data_next = {r_data[0], r_data[WIDTH-1:1]};
            3'b110: w_data_next = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
            3'b111: w_data_next = '0;
            default: w_data_next = r_data;
          endcase
        end
      end else begin
        w_data_next = {SerInL, r_data[WIDTH-1:1]};
        w_cnt_next  = r_cnt + CW'(1);
        w_done_next = w_last_shift;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_data <= w_data_next;
      r_cnt  <= w_cnt_next;
      r_done <= w_done_next;
    end
  end

  always_comb begin
    Busy    = (r_state == ST_XFER);
    Done    = r_done;
    DataOut = r_data;
    SerOut  = r_data[0];
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: stimulus pushes model predictions,
// a monitor pops and compares one per clock.
module tb_univ_shift_reg;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst, En, SerInL, SerInR, Start;
  logic [2:0]   Mode;
  logic [W-1:0] DataIn;
  logic [W-1:0] DataOut;
  logic         SerOut, Busy, Done;

  univ_shift_reg #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Mode(Mode), .DataIn(DataIn),
    .SerInL(SerInL), .SerInR(SerInR), .Start(Start),
    .DataOut(DataOut), .SerOut(SerOut), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         ser;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   stim_n = 0;

  // Reference model: value as an integer, transfer as "bits still to send".
  int unsigned m_data = 0;
  int          m_left = 0;
  bit          m_done = 0;

  task automatic model_step(input bit rst, en, input int mode, input int unsigned din,
                            input bit sl, sr, start);
    int unsigned top;
    bit done_new;
    top = 1 << (W - 1);
    done_new = 0;
    if (rst) begin
      m_data = 0; m_left = 0;
    end else if (en) begin
      if (m_left == 0) begin
        if (start) begin
          m_data = din; m_left = W;
        end else begin
          case (mode)
            1: m_data = din;
            2: m_data = (m_data * 2 + sr) % (1 << W);
            3: m_data = m_data / 2 + (sl ? top : 0);
            4: m_data = (m_data * 2) % (1 << W) + m_data / top;
            5: m_data = m_data / 2 + ((m_data % 2) * top);
            6: m_data = m_data / 2 + (m_data & top);
            7: m_data = 0;
            default: ;
          endcase
        end
      end else begin
        m_data = m_data / 2 + (sl ? top : 0);
        m_left = m_left - 1;
        done_new = (m_left == 0);
      end
    end
    m_done = done_new;
  endtask

  task automatic cyc(input bit rst, en, input int mode, input int unsigned din,
                     input bit sl, sr, start);
    exp_t e;
    @(negedge Clk);
    Rst = rst; En = en; Mode = 3'(mode); DataIn = W'(din);
    SerInL = sl; SerInR = sr; Start = start;
    model_step(rst, en, mode, din, sl, sr, start);
    e.data = W'(m_data);
    e.ser  = m_data[0];
    e.busy = (m_left > 0);
    e.done = m_done;
    q.push_back(e);
    stim_n++;
  endtask

  // Monitor: every clock the DUT presents a new state; compare away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({DataOut, SerOut, Busy, Done} !== e) begin
          errors++;
          $display("FAIL state chk%0d: got data=%h ser=%b busy=%b done=%b, expected data=%h ser=%b busy=%b done=%b",
                   checks, DataOut, SerOut, Busy, Done, e.data, e.ser, e.busy, e.done);
        end else begin
          $display("chk%0d ok data=%h ser=%b busy=%b done=%b", checks, DataOut, SerOut, Busy, Done);
        end
      end
    end
  end

  initial begin
    int wait_n;
    Rst = 1; En = 0; Mode = 0; DataIn = 0; SerInL = 0; SerInR = 0; Start = 0;
    // 1: reset then load
    cyc(1, 1, 1, 8'h5A, 1, 1, 1);
    cyc(1, 0, 3, 8'hFF, 0, 1, 0);
    cyc(0, 1, 1, 8'hA5, 0, 0, 0);
    // 2: rotate left / asr / shift left from 0x81
    cyc(0, 1, 1, 8'h81, 0, 0, 0);
    cyc(0, 1, 4, 8'h00, 0, 0, 0);
    cyc(0, 1, 1, 8'h81, 0, 0, 0);
    cyc(0, 1, 6, 8'h00, 0, 0, 0);
    cyc(0, 1, 1, 8'h81, 0, 0, 0);
    cyc(0, 1, 2, 8'h00, 0, 1, 0);
    // 3: plain transfer of 0xB4
    cyc(0, 1, 0, 8'hB4, 0, 0, 1);
    for (int i = 0; i < W + 2; i++) cyc(0, 1, 0, 8'h00, 0, 0, 0);
    // 4: stall for 3 cycles after the 4th shift
    cyc(0, 1, 0, 8'hB4, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 7, 8'hFF, 1, 1, 1);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 8'h00, 0, 0, 0);
    // 5: Start and clear requested while busy are ignored
    cyc(0, 1, 0, 8'h3C, 1, 0, 1);
    for (int i = 0; i < W + 2; i++) cyc(0, 1, 7, 8'hC3, i[0], 0, 1);
    // 6: reset after the 5th shift, then a fresh 0xFF transfer
    cyc(0, 1, 0, 8'h96, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'h00, 1, 0, 0);
    cyc(1, 1, 0, 8'h00, 0, 0, 0);
    cyc(0, 1, 0, 8'hFF, 0, 0, 1);
    for (int i = 0; i < W + 2; i++) cyc(0, 1, 0, 8'h00, 1, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8),
          int'($urandom_range(0, 7)), $urandom_range(0, 255),
          1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
    end
    // Drain the scoreboard with a bounded wait
    wait_n = 0;
    while (q.size() > 0 && wait_n < 10) begin
      @(posedge Clk);
      wait_n++;
    end
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
